// File: rtl/mining_scheduler.sv
// Bitcoin double-SHA-256 nonce search scheduler. Owns the job registers and the
// nonce loop, drives an external SHA-256 compression core twice per nonce and
// reports every nonce whose byte-reversed double hash is <= the target.
module mining_scheduler (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [255:0] cfg_midstate,
  input  logic [95:0]  cfg_tail,
  input  logic [255:0] cfg_target,
  input  logic [31:0]  cfg_nonce_start,
  input  logic [31:0]  cfg_nonce_end,
  output logic         core_start,
  output logic [255:0] core_iv,
  output logic [511:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  input  logic         found_ready,
  output logic         busy,
  output logic         exhausted,
  input  logic         abort
);

  localparam int unsigned HASH_W  = 256;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned TAIL_W  = 96;
  localparam int unsigned NONCE_W = 32;

  localparam logic [HASH_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H1_START,
    ST_H1_WAIT,
    ST_H2_START,
    ST_H2_WAIT,
    ST_CHECK,
    ST_REPORT
  } state_e;

  state_e               state_q;
  logic [HASH_W-1:0]    midstate_q;
  logic [TAIL_W-1:0]    tail_q;
  logic [HASH_W-1:0]    target_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [NONCE_W-1:0]   nonce_end_q;
  logic [HASH_W-1:0]    d2_q;
  logic [HASH_W-1:0]    core_iv_q;
  logic [BLOCK_W-1:0]   core_block_q;
  logic                 core_start_q;
  logic                 cfg_ready_q;
  logic                 busy_q;
  logic                 found_valid_q;
  logic [NONCE_W-1:0]   found_nonce_q;
  logic                 exhausted_q;

  logic [NONCE_W-1:0]   nonce_inc_d;
  logic [NONCE_W-1:0]   h1_nonce_d;
  logic [TAIL_W-1:0]    h1_tail_d;
  logic [HASH_W-1:0]    h1_iv_d;
  logic [BLOCK_W-1:0]   h1_block_d;
  logic [BLOCK_W-1:0]   h2_block_d;
  logic                 hit_c;
  logic                 last_c;
  logic                 advance_c;

  // Byte order of a SHA-256 digest is the reverse of the numeric hash compared
  // against the target.
  function automatic logic [HASH_W-1:0] byte_rev(input logic [HASH_W-1:0] x);
    logic [HASH_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(HASH_W / 8); i++) begin
      r[8*i +: 8] = x[HASH_W-1-8*i -: 8];
    end
    return r;
  endfunction

  // Next first-hash job: from the cfg bus when loading, else the next nonce of
  // the held job. Block is header bytes 64..79 plus padding for an 80-byte message.
  always_comb begin
    nonce_inc_d = nonce_q + NONCE_W'(1);
    h1_nonce_d  = nonce_inc_d;
    h1_tail_d   = tail_q;
    h1_iv_d     = midstate_q;
    if (state_q == ST_IDLE) begin
      h1_nonce_d = cfg_nonce_start;
      h1_tail_d  = cfg_tail;
      h1_iv_d    = cfg_midstate;
    end
    h1_block_d = {h1_tail_d, h1_nonce_d, 32'h8000_0000, 288'd0, 64'd640};
    // Second hash over the 32-byte first digest (d1), padded for a 256-bit message.
    h2_block_d = {core_digest, 32'h8000_0000, 160'd0, 64'd256};
  end

  // Target compare and loop-continue decision.
  always_comb begin
    hit_c     = (byte_rev(d2_q) <= target_q);
    last_c    = (nonce_q == nonce_end_q);
    advance_c = ((state_q == ST_CHECK) && !hit_c) ||
                ((state_q == ST_REPORT) && found_ready);
  end

  // Scheduler FSM with registered outputs; abort outranks every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      midstate_q    <= '0;
      tail_q        <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      d2_q          <= '0;
      core_iv_q     <= '0;
      core_block_q  <= '0;
      core_start_q  <= 1'b0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      found_valid_q <= 1'b0;
      found_nonce_q <= '0;
      exhausted_q   <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      exhausted_q  <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q       <= ST_IDLE;
        found_valid_q <= 1'b0;
        cfg_ready_q   <= 1'b1;
        busy_q        <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cfg_valid) begin
              midstate_q   <= cfg_midstate;
              tail_q       <= cfg_tail;
              target_q     <= cfg_target;
              nonce_end_q  <= cfg_nonce_end;
              nonce_q      <= h1_nonce_d;
              core_iv_q    <= h1_iv_d;
              core_block_q <= h1_block_d;
              core_start_q <= 1'b1;
              cfg_ready_q  <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= ST_H1_START;
            end
          end
          ST_H1_START: state_q <= ST_H1_WAIT;
          ST_H1_WAIT: begin
            // d1 lives in the upper half of the second-hash block register.
            if (core_done) begin
              core_iv_q    <= SHA256_IV;
              core_block_q <= h2_block_d;
              core_start_q <= 1'b1;
              state_q      <= ST_H2_START;
            end
          end
          ST_H2_START: state_q <= ST_H2_WAIT;
          ST_H2_WAIT: begin
            if (core_done) begin
              d2_q    <= core_digest;
              state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (hit_c) begin
              found_nonce_q <= nonce_q;
              found_valid_q <= 1'b1;
              state_q       <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            if (found_ready) found_valid_q <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase

        // Move to the next nonce, or finish the job at the inclusive range end.
        if (advance_c) begin
          if (last_c) begin
            exhausted_q <= 1'b1;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            nonce_q      <= h1_nonce_d;
            core_iv_q    <= h1_iv_d;
            core_block_q <= h1_block_d;
            core_start_q <= 1'b1;
            state_q      <= ST_H1_START;
          end
        end
      end
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign core_start  = core_start_q;
  assign core_iv     = core_iv_q;
  assign core_block  = core_block_q;
  assign found_valid = found_valid_q;
  assign found_nonce = found_nonce_q;
  assign busy        = busy_q;
  assign exhausted   = exhausted_q;

endmodule

// File: tb/tb_mining_scheduler.sv
// Directed bench for mining_scheduler with a behavioural SHA-256 core whose
// done pulse arrives 65 cycles after each start.
module tb_mining_scheduler;

  localparam logic [255:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [255:0] cfg_midstate = '0;
  logic [95:0]  cfg_tail = '0;
  logic [255:0] cfg_target = '0;
  logic [31:0]  cfg_nonce_start = '0;
  logic [31:0]  cfg_nonce_end = '0;
  logic         core_start;
  logic [255:0] core_iv;
  logic [511:0] core_block;
  logic         core_done;
  logic [255:0] core_digest = '0;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic         found_ready = 1'b1;
  logic         busy;
  logic         exhausted;
  logic         abort = 1'b0;
  logic         model_done = 1'b0;
  logic         inj_done = 1'b0;

  assign core_done = model_done | inj_done;

  always #5 clk = ~clk;

  mining_scheduler dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_midstate(cfg_midstate), .cfg_tail(cfg_tail), .cfg_target(cfg_target),
    .cfg_nonce_start(cfg_nonce_start), .cfg_nonce_end(cfg_nonce_end),
    .core_start(core_start), .core_iv(core_iv), .core_block(core_block),
    .core_done(core_done), .core_digest(core_digest),
    .found_valid(found_valid), .found_nonce(found_nonce), .found_ready(found_ready),
    .busy(busy), .exhausted(exhausted), .abort(abort)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression of a 512-bit block onto a chaining value.
  function automatic logic [255:0] sha_compress(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = iv;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + iv[255:224], b + iv[223:192], c + iv[191:160], d + iv[159:128],
            e + iv[127:96],  f + iv[95:64],   g + iv[63:32],   h + iv[31:0]};
  endfunction

  function automatic logic [255:0] brev(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  // Behavioural core: latches the job on start, answers 65 cycles later.
  int           mcnt = 0;
  logic [255:0] mdig = '0;
  always @(negedge clk) begin
    model_done = 1'b0;
    if (core_start) begin
      mdig = sha_compress(core_iv, core_block);
      mcnt = 65;
    end else if (mcnt != 0) begin
      if (mcnt == 1) begin
        model_done  = 1'b1;
        core_digest = mdig;
      end
      mcnt = mcnt - 1;
    end
  end

  // Event recorder, sampled just after the inputs settle.
  int           cyc = 0;
  int           start_cnt = 0;
  int           exh_cnt = 0;
  int           found_cyc = 0;
  int           exh_cyc = 0;
  logic [31:0]  found_q [$];
  logic [31:0]  h1_nonces [$];
  logic [255:0] h1_iv_last = '0;
  logic [255:0] h2_iv_last = '0;
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (core_start) begin
      start_cnt++;
      if (core_block[63:0] == 64'd640) begin
        h1_nonces.push_back(core_block[415:384]);
        h1_iv_last = core_iv;
      end else begin
        h2_iv_last = core_iv;
      end
    end
    if (found_valid && found_ready) begin
      found_q.push_back(found_nonce);
      found_cyc = cyc;
    end
    if (exhausted) begin
      exh_cnt++;
      exh_cyc = cyc;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_job(input logic [255:0] mid, input logic [95:0] tail, input logic [255:0] tgt,
                          input logic [31:0] s, input logic [31:0] e, output int lat);
    logic acc;
    acc = 1'b0;
    lat = 0;
    cfg_midstate = mid; cfg_tail = tail; cfg_target = tgt;
    cfg_nonce_start = s; cfg_nonce_end = e;
    cfg_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cfg_ready) begin
        acc = 1'b1;
        @(negedge clk);
        break;
      end
      lat++;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk("job_accept", 256'(acc), 256'(1));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk(tag, 256'(busy), 256'(0));
    tick(2);
  endtask

  logic [255:0] gen_mid, dig, ones;
  logic [95:0]  gen_tail;
  logic [255:0] gen_tgt;
  logic         stable;
  int           sb, eb, fb, hb, lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ones     = '1;
    gen_tail = 96'h4b1e5e4a_29ab5f49_ffff001d;
    gen_tgt  = {32'h0, 16'hffff, 208'd0};
    gen_mid  = sha_compress(SHA_IV, 512'h01000000_0000000000000000000000000000000000000000000000000000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa);

    // Model sanity: SHA-256("abc") and the genesis block hash.
    chk("model_abc", sha_compress(SHA_IV, {32'h61626380, 416'd0, 64'd24}),
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    dig = sha_compress(SHA_IV, {sha_compress(gen_mid, {gen_tail, 32'h1dac2b7c, 32'h80000000, 288'd0, 64'd640}),
                                32'h80000000, 160'd0, 64'd256});
    chk("model_genesis", brev(dig), 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f);

    // Reset values.
    tick(3);
    chk("rst_cfg_ready", 256'(cfg_ready), 256'(1));
    chk("rst_core_start", 256'(core_start), 256'(0));
    chk("rst_found_valid", 256'(found_valid), 256'(0));
    chk("rst_found_nonce", 256'(found_nonce), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_exhausted", 256'(exhausted), 256'(0));
    chk("rst_core_iv", core_iv, 256'(0));
    chk("rst_core_block_lo", core_block[255:0], 256'(0));
    rst = 1'b0;
    tick(2);

    // Genesis range: one hit at 0x1DAC2B7C, then exhausted after five nonces.
    sb = start_cnt; eb = exh_cnt; fb = found_q.size(); hb = h1_nonces.size();
    load_job(gen_mid, gen_tail, gen_tgt, 32'h1dac2b7a, 32'h1dac2b7e, lat);
    chk("gen_busy", 256'(busy), 256'(1));
    chk("gen_cfg_ready_low", 256'(cfg_ready), 256'(0));
    wait_idle(1200, "gen_timeout");
    chk("gen_found_cnt", 256'(found_q.size() - fb), 256'(1));
    if (found_q.size() > fb) chk("gen_found_nonce", 256'(found_q[fb]), 256'(32'h1dac2b7c));
    chk("gen_starts", 256'(start_cnt - sb), 256'(10));
    chk("gen_exh", 256'(exh_cnt - eb), 256'(1));
    chk("gen_h1_cnt", 256'(h1_nonces.size() - hb), 256'(5));
    if (h1_nonces.size() >= hb + 5) begin
      chk("gen_h1_first", 256'(h1_nonces[hb]), 256'(32'h1dac2b7a));
      chk("gen_h1_last", 256'(h1_nonces[hb+4]), 256'(32'h1dac2b7e));
    end
    chk("gen_iv_h1", h1_iv_last, gen_mid);
    chk("gen_iv_h2", h2_iv_last, SHA_IV);
    chk("gen_cfg_ready", 256'(cfg_ready), 256'(1));

    // All-ones target, ready tied high: every nonce 5..7 reported in order.
    sb = start_cnt; eb = exh_cnt; fb = found_q.size();
    load_job(SHA_IV, 96'h0123456789abcdef01234567, ones, 32'd5, 32'd7, lat);
    wait_idle(700, "ones_timeout");
    chk("ones_found_cnt", 256'(found_q.size() - fb), 256'(3));
    if (found_q.size() >= fb + 3) begin
      chk("ones_found0", 256'(found_q[fb]), 256'(5));
      chk("ones_found1", 256'(found_q[fb+1]), 256'(6));
      chk("ones_found2", 256'(found_q[fb+2]), 256'(7));
    end
    chk("ones_exh", 256'(exh_cnt - eb), 256'(1));
    chk("ones_exh_after_found", 256'(exh_cyc > found_cyc), 256'(1));
    chk("ones_starts", 256'(start_cnt - sb), 256'(6));
    chk("ones_cfg_ready", 256'(cfg_ready), 256'(1));

    // Wrapping range, target zero: nonces FFFFFFFF, 0, 1 and no hit.
    sb = start_cnt; eb = exh_cnt; fb = found_q.size(); hb = h1_nonces.size();
    load_job(gen_mid, gen_tail, 256'(0), 32'hffffffff, 32'h00000001, lat);
    wait_idle(700, "wrap_timeout");
    chk("wrap_h1_cnt", 256'(h1_nonces.size() - hb), 256'(3));
    if (h1_nonces.size() >= hb + 3) begin
      chk("wrap_h1_0", 256'(h1_nonces[hb]), 256'(32'hffffffff));
      chk("wrap_h1_1", 256'(h1_nonces[hb+1]), 256'(32'h0));
      chk("wrap_h1_2", 256'(h1_nonces[hb+2]), 256'(32'h1));
    end
    chk("wrap_starts", 256'(start_cnt - sb), 256'(6));
    chk("wrap_exh", 256'(exh_cnt - eb), 256'(1));
    chk("wrap_found", 256'(found_q.size() - fb), 256'(0));

    // Back-pressure on the result: hold ready low for 20 cycles.
    found_ready = 1'b0;
    sb = start_cnt; eb = exh_cnt;
    load_job(SHA_IV, 96'h0, ones, 32'd9, 32'd9, lat);
    for (int i = 0; i < 300; i++) begin
      if (found_valid) break;
      @(negedge clk);
    end
    chk("hold_found_valid", 256'(found_valid), 256'(1));
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(found_valid === 1'b1 && found_nonce === 32'd9 && core_start === 1'b0 && busy === 1'b1))
        stable = 1'b0;
      @(negedge clk);
    end
    chk("hold_stable", 256'(stable), 256'(1));
    chk("hold_nonce", 256'(found_nonce), 256'(9));
    found_ready = 1'b1;
    @(negedge clk);
    found_ready = 1'b0;
    chk("hold_drop_valid", 256'(found_valid), 256'(0));
    chk("hold_exhausted", 256'(exhausted), 256'(1));
    chk("hold_busy", 256'(busy), 256'(0));
    tick(2);
    chk("hold_starts", 256'(start_cnt - sb), 256'(2));
    found_ready = 1'b1;

    // Abort ten cycles into the second hash; its late done must be ignored.
    sb = start_cnt; eb = exh_cnt; fb = found_q.size();
    load_job(SHA_IV, 96'h0, ones, 32'd100, 32'd200, lat);
    for (int i = 0; i < 300; i++) begin
      if (start_cnt - sb >= 2) break;
      @(negedge clk);
    end
    chk("abort_reach_h2", 256'(start_cnt - sb), 256'(2));
    tick(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_cfg_ready", 256'(cfg_ready), 256'(1));
    chk("abort_found_valid", 256'(found_valid), 256'(0));
    chk("abort_exhausted", 256'(exhausted), 256'(0));
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    tick(70);
    chk("abort_idle_busy", 256'(busy), 256'(0));
    chk("abort_no_found", 256'(found_q.size() - fb), 256'(0));
    chk("abort_no_exh", 256'(exh_cnt - eb), 256'(0));
    chk("abort_starts", 256'(start_cnt - sb), 256'(2));
    eb = exh_cnt;
    load_job(SHA_IV, 96'h0, 256'(0), 32'd3, 32'd3, lat);
    chk("abort_new_lat", 256'(lat), 256'(0));
    chk("abort_new_busy", 256'(busy), 256'(1));
    wait_idle(400, "abort_new_timeout");
    chk("abort_new_exh", 256'(exh_cnt - eb), 256'(1));

    // cfg_valid while busy is ignored.
    sb = start_cnt; eb = exh_cnt; fb = found_q.size(); hb = h1_nonces.size();
    load_job(SHA_IV, 96'h0, ones, 32'd20, 32'd21, lat);
    tick(5);
    cfg_nonce_start = 32'd500; cfg_nonce_end = 32'd500;
    cfg_valid = 1'b1;
    tick(30);
    cfg_valid = 1'b0;
    wait_idle(500, "busycfg_timeout");
    chk("busycfg_found_cnt", 256'(found_q.size() - fb), 256'(2));
    if (found_q.size() >= fb + 2) begin
      chk("busycfg_found0", 256'(found_q[fb]), 256'(20));
      chk("busycfg_found1", 256'(found_q[fb+1]), 256'(21));
    end
    chk("busycfg_h1_cnt", 256'(h1_nonces.size() - hb), 256'(2));
    chk("busycfg_starts", 256'(start_cnt - sb), 256'(4));
    chk("busycfg_exh", 256'(exh_cnt - eb), 256'(1));

    // Asynchronous reset while waiting on the first hash.
    sb = start_cnt; eb = exh_cnt; fb = found_q.size();
    load_job(SHA_IV, 96'h0, ones, 32'd40, 32'd41, lat);
    tick(5);
    rst = 1'b1;
    #1;
    chk("rst2_cfg_ready", 256'(cfg_ready), 256'(1));
    chk("rst2_busy", 256'(busy), 256'(0));
    chk("rst2_core_start", 256'(core_start), 256'(0));
    chk("rst2_found_valid", 256'(found_valid), 256'(0));
    chk("rst2_found_nonce", 256'(found_nonce), 256'(0));
    chk("rst2_exhausted", 256'(exhausted), 256'(0));
    chk("rst2_core_iv", core_iv, 256'(0));
    @(negedge clk);
    rst = 1'b0;
    tick(70);
    chk("rst2_idle", 256'(busy), 256'(0));
    chk("rst2_starts", 256'(start_cnt - sb), 256'(1));
    chk("rst2_no_found", 256'(found_q.size() - fb), 256'(0));
    chk("rst2_no_exh", 256'(exh_cnt - eb), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
